// File: rtl/adc_scan_seq.sv
// adc_scan_seq: on each sample tick, scans ADC channels through an external SPI controller
// and queues tagged results in a first-word-fall-through FIFO. Define ADC_SEQ_TIMEOUT_EN for the SPI watchdog.
module adc_scan_seq #(
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned SAMPLE_PERIOD  = 2000,
    parameter int unsigned SPI_WIDTH      = 16,
    parameter int unsigned SAMPLE_WIDTH   = 10,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    enable_in,
    output logic [SPI_WIDTH-1:0]    spi_data_out,
    output logic                    spi_trigger_out,
    input  logic [SPI_WIDTH-1:0]    spi_data_in,
    input  logic                    spi_valid_in,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic [2:0]              channel_out,
    output logic                    frame_start_out,
    output logic                    sample_valid_out,
    input  logic                    sample_ready_in,
    output logic                    overflow_out,
    output logic                    overrun_out,
    output logic                    timeout_out
);
    localparam int unsigned CNT_W  = $clog2(SAMPLE_PERIOD);
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned PAD_W  = SPI_WIDTH - 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [2:0]       CH_LAST  = 3'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_STORE} state_t;

    typedef struct packed {
        logic                    frame_start;
        logic [2:0]              channel;
        logic [SAMPLE_WIDTH-1:0] sample;
    } entry_t;

    state_t                  state, state_n;
    logic [2:0]              ch, ch_n;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_n;
    logic                    push;
    logic                    wd_expired;

    // Sample tick generator, held cleared while scanning is disabled
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = enable_in && (tick_cnt == CNT_LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tick_cnt <= '0;
        end else if (!enable_in || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wd_cnt      <= '0;
            timeout_out <= 1'b0;
        end else begin
            if (state != ST_WAIT) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (state == ST_WAIT && !spi_valid_in && wd_expired) begin
                timeout_out <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign wd_expired         = 1'b0;
    assign timeout_out        = 1'b0;
`endif

    // Only the low result bits of the SPI word carry the conversion
    logic unused_spi_bits;
    assign unused_spi_bits = ^spi_data_in[SPI_WIDTH-1:SAMPLE_WIDTH];

    // Scan sequencer next-state logic
    always_comb begin
        state_n  = state;
        ch_n     = ch;
        sample_n = sample_q;
        push     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_n = ST_ISSUE;
                    ch_n    = '0;
                end
            end
            ST_ISSUE: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (spi_valid_in) begin
                    sample_n = spi_data_in[SAMPLE_WIDTH-1:0];
                    state_n  = ST_STORE;
                end else if (wd_expired) begin
                    sample_n = '0;
                    state_n  = ST_STORE;
                end
            end
            ST_STORE: begin
                push = 1'b1;
                if (ch == CH_LAST || !enable_in) begin
                    state_n = ST_IDLE;
                    ch_n    = '0;
                end else begin
                    state_n = ST_ISSUE;
                    ch_n    = ch + 3'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                ch_n    = '0;
            end
        endcase
    end

    // Trigger and command are registered on entry to ISSUE so they align with that state
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= ST_IDLE;
            ch              <= '0;
            sample_q        <= '0;
            spi_trigger_out <= 1'b0;
            spi_data_out    <= '0;
            overrun_out     <= 1'b0;
        end else begin
            state           <= state_n;
            ch              <= ch_n;
            sample_q        <= sample_n;
            spi_trigger_out <= (state_n == ST_ISSUE);
            if (state_n == ST_ISSUE) begin
                spi_data_out <= {2'b11, ch_n, {PAD_W{1'b0}}};
            end
            if (tick && state != ST_IDLE) begin
                overrun_out <= 1'b1;
            end
        end
    end

    // Output FIFO with a registered head entry
    entry_t           mem [FIFO_DEPTH];
    entry_t           push_entry, head_n, head_q;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic             full, pop, push_ok;

    assign push_entry = '{frame_start: (ch == 3'(0)), channel: ch, sample: sample_q};
    assign full       = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                        (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign pop        = sample_valid_out && sample_ready_in;
    assign push_ok    = push && (!full || pop);
    assign wr_ptr_n   = push_ok ? wr_ptr + PTR_W'(1) : wr_ptr;
    assign rd_ptr_n   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    // A push landing in the slot about to become head bypasses the array
    always_comb begin
        head_n = mem[rd_ptr_n[ADDR_W-1:0]];
        if (push_ok && (wr_ptr[ADDR_W-1:0] == rd_ptr_n[ADDR_W-1:0])) begin
            head_n = push_entry;
        end
        if (wr_ptr_n == rd_ptr_n) begin
            head_n = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            head_q           <= '0;
            sample_valid_out <= 1'b0;
            overflow_out     <= 1'b0;
        end else begin
            wr_ptr           <= wr_ptr_n;
            rd_ptr           <= rd_ptr_n;
            head_q           <= head_n;
            sample_valid_out <= (wr_ptr_n != rd_ptr_n);
            if (push && full && !pop) begin
                overflow_out <= 1'b1;
            end
        end
    end

    assign sample_out      = head_q.sample;
    assign channel_out     = head_q.channel;
    assign frame_start_out = head_q.frame_start;

endmodule

// File: tb/tb_adc_scan_seq.sv
// tb_adc_scan_seq: randomized bench with an SPI controller model and a queue-based FIFO scoreboard.
module tb_adc_scan_seq;
    localparam int unsigned NCH   = 4;
    localparam int unsigned SP    = 64;
    localparam int unsigned SPIW  = 16;
    localparam int unsigned SW    = 10;
    localparam int unsigned DEPTH = 8;

    logic            clk_in = 1'b0;
    logic            rst_n_in, enable_in, spi_trigger_out, spi_valid_in;
    logic            frame_start_out, sample_valid_out, sample_ready_in;
    logic            overflow_out, overrun_out, timeout_out;
    logic [SPIW-1:0] spi_data_out, spi_data_in;
    logic [SW-1:0]   sample_out;
    logic [2:0]      channel_out;

    adc_scan_seq #(
        .NUM_CHANNELS  (NCH),
        .SAMPLE_PERIOD (SP),
        .SPI_WIDTH     (SPIW),
        .SAMPLE_WIDTH  (SW),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .enable_in       (enable_in),
        .spi_data_out    (spi_data_out),
        .spi_trigger_out (spi_trigger_out),
        .spi_data_in     (spi_data_in),
        .spi_valid_in    (spi_valid_in),
        .sample_out      (sample_out),
        .channel_out     (channel_out),
        .frame_start_out (frame_start_out),
        .sample_valid_out(sample_valid_out),
        .sample_ready_in (sample_ready_in),
        .overflow_out    (overflow_out),
        .overrun_out     (overrun_out),
        .timeout_out     (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic          frame;
        logic [2:0]    ch;
        logic [SW-1:0] sample;
    } exp_t;

    // Reference state: expected FIFO contents, expected next channel, SPI transaction in flight
    exp_t            q[$];
    int              exp_ch     = 0;
    bit              txn_active = 0;
    int              txn_left   = 0;
    int              txn_ch     = 0;
    logic [SPIW-1:0] txn_data   = '0;
    exp_t            txn_entry  = '0;
    bit              pend_push  = 0;
    exp_t            pend_entry = '0;
    bit              ovf_model  = 0;
    int              trig_count = 0;
    int              lat_min    = 1;
    int              lat_max    = 10;

    initial begin : spi_and_scoreboard
        logic            c_ready, c_valid, c_trig, c_rst, prev_trig, valid_next;
        logic [SPIW-1:0] c_cmd, exp_cmd;
        bit              do_push, pop;
        exp_t            push_e;
        logic [2:0]      ch3;
        spi_valid_in = 1'b0;
        spi_data_in  = '0;
        prev_trig    = 1'b0;
        forever begin
            @(negedge clk_in);
            c_rst   = rst_n_in;
            c_ready = sample_ready_in;
            c_valid = spi_valid_in;
            c_trig  = spi_trigger_out;
            c_cmd   = spi_data_out;
            if (!c_rst) begin
                q.delete();
                pend_push  = 0;
                txn_active = 0;
                ovf_model  = 0;
                exp_ch     = 0;
            end else begin
                if (q.size() != 0) begin
                    check_eq("head", 64'({sample_valid_out, frame_start_out, channel_out, sample_out}),
                             64'({1'b1, q[0]}));
                end else begin
                    check_eq("head_valid", 64'(sample_valid_out), 64'(0));
                end
                check_eq("overflow", 64'(overflow_out), 64'(ovf_model));
            end
            @(posedge clk_in);
            valid_next = 1'b0;
            if (c_rst) begin
                do_push   = pend_push;
                push_e    = pend_entry;
                pend_push = 0;
                if (c_valid) begin
                    pend_push  = 1;
                    pend_entry = txn_entry;
                end
                pop = (q.size() != 0) && c_ready;
                if (do_push && q.size() == DEPTH && !pop) begin
                    ovf_model = 1;
                end else begin
                    if (pop) void'(q.pop_front());
                    if (do_push) q.push_back(push_e);
                end
                if (c_trig) begin
                    ch3     = 3'(exp_ch);
                    exp_cmd = {2'b11, ch3, {(SPIW-5){1'b0}}};
                    check_eq("cmd", 64'(c_cmd), 64'(exp_cmd));
                    check_eq("trig_busy", 64'(txn_active), 64'(0));
                    check_eq("trig_pulse", 64'(prev_trig), 64'(0));
                    txn_active = 1;
                    txn_ch     = exp_ch;
                    txn_data   = 16'($urandom);
                    txn_left   = $urandom_range(lat_max, lat_min);
                    exp_ch     = (exp_ch + 1) % NCH;
                    trig_count++;
                end
                if (txn_active) begin
                    txn_left--;
                    if (txn_left == 0) begin
                        valid_next = 1'b1;
                        txn_active = 0;
                        txn_entry  = {txn_ch == 0, 3'(txn_ch), txn_data[SW-1:0]};
                    end
                end
                prev_trig = c_trig;
            end else begin
                prev_trig = 1'b0;
            end
            #1;
            spi_valid_in = valid_next;
            spi_data_in  = valid_next ? txn_data : 16'($urandom);
        end
    end

    task automatic wait_first_trig(output int n);
        n = 0;
        for (int i = 1; i <= 4 * SP; i++) begin
            @(posedge clk_in);
            #1;
            if (spi_trigger_out) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_cycles(input int n, input bit rand_ready);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #2;
            if (rand_ready) sample_ready_in = 1'($urandom_range(1, 0));
        end
    endtask

    task automatic wait_txn(input int want_ch, output bit found);
        found = 0;
        for (int i = 0; i < 6 * SP; i++) begin
            @(posedge clk_in);
            #2;
            if (txn_active && (want_ch < 0 || txn_ch == want_ch)) begin
                found = 1;
                break;
            end
        end
    endtask

    initial begin : stimulus
        int n;
        int tc;
        bit found;
        rst_n_in        = 1'b0;
        enable_in       = 1'b0;
        sample_ready_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_eq("reset_outs", 64'({spi_data_out, spi_trigger_out, sample_out, channel_out, frame_start_out,
                                    sample_valid_out, overflow_out, overrun_out, timeout_out}), 64'(0));
        @(posedge clk_in);
        #2 rst_n_in = 1'b1;

        // First tick lands SAMPLE_PERIOD-1 cycles after enable; trigger one cycle later
        @(posedge clk_in);
        #2;
        enable_in       = 1'b1;
        sample_ready_in = 1'b1;
        wait_first_trig(n);
        check_eq("first_trig", 64'(n), 64'(SP));

        run_cycles(20 * SP, 1'b1);
        sample_ready_in = 1'b1;
        run_cycles(SP, 1'b0);
        check_eq("no_overrun", 64'(overrun_out), 64'(0));
        check_eq("no_overflow", 64'(overflow_out), 64'(0));

        // Back-pressure across three scans
        wait_txn(0, found);
        check_eq("find_scan", 64'(found), 64'(1));
        sample_ready_in = 1'b0;
        run_cycles(3 * SP - 8, 1'b0);
        check_eq("ovf_flag", 64'(overflow_out), 64'(1));
        check_eq("ovf_head", 64'({sample_valid_out, frame_start_out, channel_out}), 64'({1'b1, 1'b1, 3'd0}));
        sample_ready_in = 1'b1;
        run_cycles(2 * SP, 1'b0);

        // Long SPI latency forces ticks to arrive mid-scan
        lat_min = 30;
        lat_max = 30;
        run_cycles(6 * SP, 1'b0);
        check_eq("overrun_flag", 64'(overrun_out), 64'(1));
        lat_min = 1;
        lat_max = 10;
        run_cycles(4 * SP, 1'b0);

        // Disable during the channel 1 transaction
        lat_min = 20;
        lat_max = 20;
        wait_txn(1, found);
        check_eq("find_ch1_wait", 64'(found), 64'(1));
        tc        = trig_count;
        enable_in = 1'b0;
        run_cycles(3 * SP, 1'b0);
        check_eq("no_trig_after_drop", 64'(trig_count - tc), 64'(0));
        check_eq("drained_after_drop", 64'(sample_valid_out), 64'(0));
        exp_ch    = 0;
        enable_in = 1'b1;
        wait_first_trig(n);
        check_eq("reenable_trig", 64'(n), 64'(SP));

        // Asynchronous reset during WAIT
        wait_txn(-1, found);
        check_eq("find_wait", 64'(found), 64'(1));
        #1 rst_n_in = 1'b0;
        #1;
        check_eq("async_rst_outs", 64'({spi_data_out, spi_trigger_out, sample_out, channel_out, frame_start_out,
                                        sample_valid_out, overflow_out, overrun_out, timeout_out}), 64'(0));
        repeat (2) @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        wait_first_trig(n);
        check_eq("post_rst_trig", 64'(n), 64'(SP));
        check_eq("post_rst_cmd", 64'(spi_data_out), 64'(16'hC000));
        lat_min = 1;
        lat_max = 10;
        run_cycles(2 * SP, 1'b1);
        sample_ready_in = 1'b1;
        run_cycles(SP, 1'b0);
        check_eq("timeout_off", 64'(timeout_out), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
